restoring_div_param: RTL and testbench

Parametrised successor of the 8-bit restoring divider. It performs WIDTH-bit unsigned or signed (two's-complement) division, one quotient bit per clock. It has a start/busy/done handshake, a divide-by-zero flag and a correct (WIDTH+1)-bit partial remainder, so divisors with the MSB set are handled. It sits behind the ALU control unit alongside the multiplier and is driven by a single-cycle start request.

---
 rtl/restoring_div_param.sv | 170 +++++++++++++++++
 tb/tb_restoring_div_param.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/restoring_div_param.sv
// restoring_div_param
//   Multi-cycle restoring divider, WIDTH-bit unsigned or two's-complement
//   signed operands, one quotient bit per clock.
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous, active-high reset (highest priority)
//     start        request, sampled only while idle
//     signed_mode  1 = two's-complement operands, captured with start
//     dividend     captured with start
//     divisor      captured with start
//     busy         high while a division is in flight (RUN or FINISH)
//     done         one-cycle pulse, results valid from this cycle
//     quotient     registered result, held until the next done
//     remainder    registered result, held until the next done
//     div_by_zero  registered flag, updated with each done
//
//   Handshake: start is accepted on a rising edge only when busy is low.
//   busy goes high the cycle after acceptance and drops in the done cycle,
//   so a new start may be presented in the same cycle done is high.
//   start while busy is ignored. Operand inputs are only sampled on the
//   accepting edge.
module restoring_div_param #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;        // shifting dividend / quotient
  // The stored partial remainder is always below the divisor, so WIDTH
  // bits hold it exactly; the extra bit lives in the shifted/trial values.
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;    // divisor magnitude
  logic [WIDTH-1:0]   orig_q, orig_d;  // raw dividend for divide-by-zero
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     r_sh, trial;
  logic [WIDTH-1:0]   q_sh;

  // Magnitudes wrap for MIN, which still yields the correct unsigned value.
  assign a_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;

  assign r_sh  = {r_q, q_q[WIDTH-1]};
  assign q_sh  = {q_q[WIDTH-2:0], 1'b0};
  assign trial = r_sh - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    orig_d  = orig_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d     = a_mag;
          r_d     = '0;
          cnt_d   = '0;
          dvs_d   = b_mag;
          orig_d  = dividend;
          qneg_d  = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rneg_d  = signed_mode & dividend[WIDTH-1];
          dz_d    = (divisor == '0);
          state_d = (divisor == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        // A clear borrow bit means the divisor fits: keep the difference.
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = q_sh | WIDTH'(1);
        end else begin
          r_d = r_sh[WIDTH-1:0];
          q_d = q_sh;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dz_q) begin
          quo_d = '1;
          rem_d = orig_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = qneg_q ? -q_q : q_q;
          rem_d = rneg_q ? -r_q : r_q;
          dbz_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      orig_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      orig_q  <= orig_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_div_param.sv
// Bench for restoring_div_param: one WIDTH=8 and one WIDTH=16 instance,
// directed cases followed by random operands, checked against an
// arithmetic reference model.
module tb_restoring_div_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start8, sm8, busy8, done8, dz8;
  logic [7:0]  a8, b8, q8, r8;
  logic        start16, sm16, busy16, done16, dz16;
  logic [15:0] a16, b16, q16, r16;

  restoring_div_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dz8)
  );

  restoring_div_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .dividend(a16), .divisor(b16), .busy(busy16), .done(done16),
    .quotient(q16), .remainder(r16), .div_by_zero(dz16)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [64:0] exp_q[$];  // {div_by_zero, quotient, remainder}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended values.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input bit s, output logic [31:0] q, output logic [31:0] r,
                                output bit dz);
    longint m = (longint'(1) << w) - 1;
    longint sa = longint'(a);
    longint sb = longint'(b);
    dz = (b == 0);
    if (dz) begin
      q = 32'(m);
      r = a;
    end else begin
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      q = 32'((sa / sb) & m);
      r = 32'((sa % sb) & m);
    end
  endfunction

  function automatic logic cur_done(input bit wide);
    return wide ? done16 : done8;
  endfunction

  function automatic logic cur_busy(input bit wide);
    return wide ? busy16 : busy8;
  endfunction

  // ---------------- driver ----------------
  // Called at a negative edge with the DUT idle (or in its done cycle).
  // Returns at the negative edge of the done cycle. ign_at > 0 pulses a
  // spurious start in that busy cycle.
  task automatic run_op(input bit wide, input logic [31:0] a_in, input logic [31:0] b_in,
                        input bit s, input int ign_at);
    int          w = wide ? 16 : 8;
    logic [31:0] mask = wide ? 32'h0000_FFFF : 32'h0000_00FF;
    logic [31:0] a = a_in & mask;
    logic [31:0] b = b_in & mask;
    logic [31:0] eq, er;
    logic [64:0] ex;
    bit          ed, seen;
    int          n, busy_n, exp_lat;

    model(w, a, b, s, eq, er, ed);
    exp_q.push_back({ed, eq, er});
    exp_lat = ed ? 2 : w + 2;

    if (wide) begin start16 = 1'b1; sm16 = s; a16 = a[15:0]; b16 = b[15:0]; end
    else      begin start8  = 1'b1; sm8  = s; a8  = a[7:0];  b8  = b[7:0];  end
    @(negedge clk);
    n = 1; busy_n = 0; seen = 1'b0;
    while (n <= 40 && !seen) begin
      // Operand inputs wander during the run; they must not matter.
      if (wide) begin a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom); end
      else      begin a8  = 8'($urandom);  b8  = 8'($urandom);  sm8  = 1'($urandom); end
      if (cur_done(wide)) begin
        seen = 1'b1;
      end else begin
        if (cur_busy(wide)) busy_n++;
        if (wide) start16 = (n == ign_at);
        else      start8  = (n == ign_at);
        @(negedge clk);
        n++;
      end
    end
    if (wide) start16 = 1'b0; else start8 = 1'b0;

    check("latency", n, exp_lat);
    check("busy_cycles", busy_n, exp_lat - 1);
    check("busy_in_done", cur_busy(wide), 1'b0);
    ex = exp_q.pop_front();
    check("quotient",    wide ? 32'(q16) : 32'(q8), ex[63:32]);
    check("remainder",   wide ? 32'(r16) : 32'(r8), ex[31:0]);
    check("div_by_zero", wide ? dz16 : dz8, ex[64]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dn;
    rst = 1'b1;
    start8 = 1'b0;  sm8 = 1'b0;  a8 = '0;  b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_q", q8, 8'h00);
    check("rst_r", r8, 8'h00);
    check("rst_dz", dz8, 1'b0);
    check("rst_q16", q16, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Directed 8-bit cases; each starts in the previous done cycle.
    run_op(0, 200, 7, 0, 0);
    run_op(0, 250, 200, 0, 0);
    run_op(0, 255, 1, 0, 0);
    run_op(0, 32'hF9, 32'h02, 1, 0);
    run_op(0, 32'h07, 32'hFE, 1, 0);
    run_op(0, 32'h80, 32'hFF, 1, 0);
    run_op(0, 13, 0, 0, 0);
    run_op(0, 9, 4, 0, 0);          // clears div_by_zero
    run_op(0, 100, 3, 0, 3);        // spurious start in cycle 3

    // Reset in cycle 5 of a run: outputs clear, no done follows.
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd100; b8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy8, 1'b0);
    check("mid_rst_done", done8, 1'b0);
    check("mid_rst_q", q8, 8'h00);
    check("mid_rst_r", r8, 8'h00);
    check("mid_rst_dz", dz8, 1'b0);
    dn = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done8) dn++;
    end
    check("mid_rst_no_done", dn, 0);

    run_op(0, 100, 3, 0, 0);

    // Random 8-bit operands, mixed modes, occasional zero divisor.
    for (int i = 0; i < 30; i++)
      run_op(0, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
             1'($urandom), 0);

    // 16-bit instance.
    run_op(1, 50000, 300, 0, 0);
    run_op(1, 32'h8000, 7, 1, 0);
    run_op(1, 32'h8000, 32'hFFFF, 1, 0);
    run_op(1, 1234, 0, 1, 0);
    for (int i = 0; i < 10; i++)
      run_op(1, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
             1'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
